unit_wb_buffer: RTL and testbench

Per-unit result buffer placed between a multi-cycle execution unit and the writeback arbiter. It accepts completed results (id, rd) from the unit, queues them in order, and presents the oldest entry on a unit_writeback_interface-style done/id/rd/ack handshake. This decouples unit issue from arbitration stalls, so a unit can keep completing while lower-priority in the writeback group.

---
 rtl/unit_wb_buffer.sv | 108 ++++++++++
 tb/tb_unit_wb_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/unit_wb_buffer.sv
`default_nettype none
// ==========================================================================
// unit_wb_buffer : in-order result queue between an execution unit and the
//                  writeback arbiter (done/id/rd/ack handshake).  Rev 1.0
// ==========================================================================
module unit_wb_buffer #(
   parameter int DEPTH          = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 3,
   parameter bit CHECK_PROTOCOL = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [ID_WIDTH-1:0]      in_id,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     done,
   output logic [ID_WIDTH-1:0]      id,
   output logic [DATA_WIDTH-1:0]    rd,
   input  logic                     ack,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = ID_WIDTH + DATA_WIDTH;
   localparam logic [PW-1:0] C_FULL = PW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          push;
   logic          pop;

   // Handshake outputs come straight from the registered count, so ack never
   // feeds back into in_ready within a cycle.
   assign in_ready = (count_q != C_FULL);
   assign done     = (count_q != '0);
   assign push     = in_valid & in_ready;
   assign pop      = ack & done;
   assign {id, rd} = mem_q[rd_ptr_q[AW-1:0]];
   assign count    = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {in_id, in_data};
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + PW'(push) - PW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale entries are never visible while done=0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count_q <= C_FULL);
         assert (!(push && (count_q == C_FULL)));
         assert (!(pop && (count_q == '0)));
         assert (done == (count_q != '0));
      end
   end

   generate
      if (CHECK_PROTOCOL) begin : g_protocol_checks
         always_ff @(posedge clk) begin
            if (!rst) begin
               assert (!(in_valid && !in_ready));
               assert (!(ack && !done));
            end
         end
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_unit_wb_buffer.sv
`default_nettype none
// ==========================================================================
// tb_unit_wb_buffer : directed bench with a queue-based reference model.
//                     Rev 1.0
// ==========================================================================
module tb_unit_wb_buffer;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int IW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [IW-1:0] in_id;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          flush;
   logic          done;
   logic [IW-1:0] id;
   logic [DW-1:0] rd;
   logic          ack;
   logic [2:0]    count;

   int tests = 0;
   int fails = 0;

   unit_wb_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_id(in_id),
      .in_data(in_data), .in_ready(in_ready), .flush(flush), .done(done),
      .id(id), .rd(rd), .ack(ack), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of {id,data}, updated from the rules.
   logic [IW+DW-1:0] q[$];

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         automatic bit can_push = in_valid && (q.size() != DEPTH);
         automatic bit can_pop  = ack && (q.size() != 0);
         if (can_pop) void'(q.pop_front());
         if (can_push) q.push_back({in_id, in_data});
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("count", 64'(count), 64'(q.size()));
         chk("done", 64'(done), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
         if (q.size() != 0) begin
            chk("head", 64'({id, rd}), 64'(q[0]));
         end
      end
   end

   task automatic drive(input logic v, input logic [IW-1:0] i, input logic [DW-1:0] d,
                        input logic a, input logic f);
      in_valid = v; in_id = i; in_data = d; ack = a; flush = f;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n;
      rst = 1'b1; in_valid = 1'b0; in_id = '0; in_data = '0; ack = 1'b0; flush = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Single pass with ack held high
      drive(1, 3'd3, 32'hDEADBEEF, 1, 0);
      chk("sp_done", 64'(done), 64'd1);
      chk("sp_id", 64'(id), 64'd3);
      chk("sp_rd", 64'(rd), 64'hDEADBEEF);
      drive(0, 0, 0, 1, 0);
      chk("sp_done2", 64'(done), 64'd0);

      // Fill to full, refuse a fifth push, then drain in order
      for (int i = 0; i < 4; i++) drive(1, IW'(i), DW'(32'h10 + i), 0, 0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      drive(1, 3'd4, 32'h14, 0, 0);
      chk("full_refuse", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_id", 64'(id), 64'(i));
         chk("drain_rd", 64'(rd), 64'(32'h10 + i));
         drive(0, 0, 0, 1, 0);
      end
      chk("drain_done", 64'(done), 64'd0);

      // Simultaneous push and pop at count=2
      drive(1, 3'd0, 32'h20, 0, 0);
      drive(1, 3'd1, 32'h21, 0, 0);
      drive(1, 3'd5, 32'h25, 1, 0);
      chk("pp_count", 64'(count), 64'd2);
      chk("pp_head", 64'(id), 64'd1);
      drive(0, 0, 0, 1, 0);
      chk("pp_last", 64'(id), 64'd5);
      chk("pp_last_rd", 64'(rd), 64'h25);
      drive(0, 0, 0, 1, 0);

      // Wrap-around stream of 20 results
      k = 0; n = 0;
      for (int cyc = 0; cyc < 300 && (k < 20); cyc++) begin
         automatic logic a = cyc[1];
         automatic logic v = (n < 20) && (q.size() != DEPTH);
         if (done && a) begin
            chk("wrap_id", 64'(id), 64'(k % 8));
            chk("wrap_rd", 64'(rd), 64'(k));
            k++;
         end
         drive(v, IW'(n % 8), DW'(n), a, 0);
         if (v) n++;
      end
      chk("wrap_received", 64'(k), 64'd20);
      chk("wrap_empty", 64'(done), 64'd0);

      // Flush beats a concurrent push and pop
      for (int i = 1; i <= 3; i++) drive(1, IW'(i), DW'(32'h30 + i), 0, 0);
      chk("fl_pre", 64'(count), 64'd3);
      drive(1, 3'd7, 32'h77, 1, 1);
      chk("fl_count", 64'(count), 64'd0);
      chk("fl_done", 64'(done), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      drive(0, 0, 0, 1, 0);
      chk("fl_no7", 64'(done), 64'd0);

      // Reset mid-stream
      for (int i = 4; i <= 6; i++) drive(1, IW'(i), DW'(32'h40 + i), 0, 0);
      chk("rs_pre", 64'(count), 64'd3);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rs_count", 64'(count), 64'd0);
      chk("rs_done", 64'(done), 64'd0);
      chk("rs_ready", 64'(in_ready), 64'd1);
      drive(1, 3'd2, 32'h222, 0, 0);
      chk("rs_head_done", 64'(done), 64'd1);
      chk("rs_head_id", 64'(id), 64'd2);
      chk("rs_head_rd", 64'(rd), 64'h222);
      drive(0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
